mem_ctrl: RTL and testbench

- Responder end of the cache-to-memory request protocol. Serves dcache load/store requests and icache 4-byte fetches against the byte-wide unified RAM/IO bus.
- Serialises each request into byte accesses and returns one done pulse with assembled data.
- Sits between dcache/icache and the top-level RAM and IO ports.

---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_ctrl_if.sv | 45 ++++
 rtl/mem_ctrl_req_slot.sv | 49 ++++
 rtl/mem_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the cache-to-memory request responder.
package mem_ctrl_pkg;

  localparam int unsigned MC_ADDR_W    = 32;
  localparam logic [31:0] MC_IO_BASE   = 32'h0003_0000;
  localparam logic [2:0]  MC_FETCH_LEN = 3'd4;

  // Controller FSM states.
  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  // Which requester owns the access in flight.
  typedef enum logic {
    PORT_DC = 1'b0,
    PORT_IC = 1'b1
  } mc_port_e;

  // One queued or active request.
  typedef struct packed {
    logic        ls;   // 1 = store
    logic [31:0] pc;   // start byte address
    logic [31:0] dt;   // store data, little-endian
    logic [2:0]  len;  // byte count
  } mc_req_t;

  // Little-endian byte lane i of a 32-bit word.
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Cache request ports plus the byte-wide RAM/IO bus of mem_ctrl.
// slave = the controller, master = the caches / memory side.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                 iDC_en;
  logic                 iDC_ls;
  logic [31:0]          iDC_pc;
  logic [31:0]          iDC_dt;
  logic [2:0]           iDC_len;
  logic                 oDC_done;
  logic [31:0]          oDC_dt;
  logic                 oDC_wait;

  logic                 iIC_en;
  logic [31:0]          iIC_pc;
  logic                 oIC_done;
  logic [31:0]          oIC_dt;
  logic                 oIC_wait;

  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;
  logic [MC_ADDR_W-1:0] mem_a;
  logic                 mem_wr;
  logic                 io_buffer_full;

  modport slave (
    input  iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len,
    output oDC_done, oDC_dt, oDC_wait,
    input  iIC_en, iIC_pc,
    output oIC_done, oIC_dt, oIC_wait,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len,
    input  oDC_done, oDC_dt, oDC_wait,
    output iIC_en, iIC_pc,
    input  oIC_done, oIC_dt, oIC_wait,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl_req_slot.sv
// mem_req_slot: one-entry request latch. A pulse is captured when the slot
// is empty; a pulse while full is ignored. Dispatch clears the slot.
module mem_req_slot
  import mem_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,     // asynchronous, active-low
  input  logic    rdy,     // low freezes the slot
  input  logic    push_i,
  input  mc_req_t req_i,
  input  logic    clr_i,
  output logic    full_o,
  output mc_req_t req_o,
  output logic    wait_o
);

  logic    full_q, full_d;
  mc_req_t req_q,  req_d;

  // Next slot contents: clear on dispatch, else capture into an empty slot.
  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (push_i && !full_q) begin
      full_d = 1'b1;
      req_d  = req_i;
    end else begin
      full_d = full_q;
    end
  end

  // Slot storage, frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else if (rdy) begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  assign full_o = full_q;
  assign req_o  = req_q;
  assign wait_o = full_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises dcache load/store and icache fetch requests into
// byte accesses on the unified RAM/IO bus and returns one done pulse.
// Optional build macro MEMCTRL_IO_STALL_EN: IO-space writes stall while
// io_buffer_full is high; without it io_buffer_full is ignored.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W  = MC_ADDR_W,
  parameter logic [ADDR_W-1:0] IO_BASE = MC_IO_BASE
)(
  input  logic      clk,
  input  logic      rst,   // asynchronous, active-low
  input  logic      rdy,   // low freezes all state
  mem_ctrl_if.slave bus
);

  mc_state_e   state_q,   state_d;
  logic [2:0]  idx_q,     idx_d;
  mc_req_t     act_q,     act_d;
  mc_port_e    port_q,    port_d;
  logic [31:0] data_q,    data_d;
  logic        dc_done_q, dc_done_d;
  logic        ic_done_q, ic_done_d;
  logic [31:0] dc_dt_q,   dc_dt_d;
  logic [31:0] ic_dt_q,   ic_dt_d;

  mc_req_t     dc_in_s, ic_in_s, dc_req_s, ic_req_s;
  logic        dc_full_s, ic_full_s, dc_wait_s, ic_wait_s;
  logic        dc_disp_s, ic_disp_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [1:0]  lane_s;
  logic        is_io_s, stall_s;
  logic [ADDR_W-1:0] mem_a_s;
  logic [7:0]  mem_dout_s;
  logic        mem_wr_s;

  assign dc_in_s = '{ls: bus.iDC_ls, pc: bus.iDC_pc, dt: bus.iDC_dt, len: bus.iDC_len};
  assign ic_in_s = '{ls: 1'b0, pc: bus.iIC_pc, dt: 32'd0, len: MC_FETCH_LEN};

  // dcache always wins arbitration; icache only dispatches when dcache is empty.
  assign dc_disp_s = (state_q == MC_IDLE) && dc_full_s;
  assign ic_disp_s = (state_q == MC_IDLE) && !dc_full_s && ic_full_s;

  mem_req_slot u_dc_slot (
    .clk(clk), .rst(rst), .rdy(rdy),
    .push_i(bus.iDC_en), .req_i(dc_in_s), .clr_i(dc_disp_s),
    .full_o(dc_full_s), .req_o(dc_req_s), .wait_o(dc_wait_s)
  );

  mem_req_slot u_ic_slot (
    .clk(clk), .rst(rst), .rdy(rdy),
    .push_i(bus.iIC_en), .req_i(ic_in_s), .clr_i(ic_disp_s),
    .full_o(ic_full_s), .req_o(ic_req_s), .wait_o(ic_wait_s)
  );

  // Address of the byte being accessed; wraps modulo 2^ADDR_W.
  assign cur_addr_s = act_q.pc[ADDR_W-1:0] + ADDR_W'(idx_q);
  assign is_io_s    = (cur_addr_s >= IO_BASE);
  // A read byte arrives one cycle after its address, so capture lags idx by one.
  assign lane_s     = 2'(idx_q - 3'd1);

`ifdef MEMCTRL_IO_STALL_EN
  assign stall_s = is_io_s & bus.io_buffer_full;
`else
  logic unused_io_s;
  assign stall_s     = 1'b0;
  assign unused_io_s = is_io_s ^ bus.io_buffer_full;
`endif

  // State register, frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MC_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE: begin
        if (dc_full_s) begin
          state_d = dc_req_s.ls ? MC_WRITE : MC_READ;
        end else if (ic_full_s) begin
          state_d = MC_READ;
        end else begin
          state_d = MC_IDLE;
        end
      end
      MC_READ: begin
        // idx == len is the trailing capture-only cycle.
        if (idx_q >= act_q.len) begin
          state_d = MC_DONE;
        end else begin
          state_d = MC_READ;
        end
      end
      MC_WRITE: begin
        if (!stall_s && ((idx_q + 3'd1) >= act_q.len)) begin
          state_d = MC_DONE;
        end else begin
          state_d = MC_WRITE;
        end
      end
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  // Datapath next values: dispatch, byte counter, read assembly, done pulses.
  always_comb begin
    idx_d     = idx_q;
    act_d     = act_q;
    port_d    = port_q;
    data_d    = data_q;
    dc_done_d = 1'b0;
    ic_done_d = 1'b0;
    dc_dt_d   = dc_dt_q;
    ic_dt_d   = ic_dt_q;
    case (state_q)
      MC_IDLE: begin
        if (dc_full_s) begin
          act_d  = dc_req_s;
          port_d = PORT_DC;
          idx_d  = 3'd0;
          data_d = 32'd0;
        end else if (ic_full_s) begin
          act_d  = ic_req_s;
          port_d = PORT_IC;
          idx_d  = 3'd0;
          data_d = 32'd0;
        end else begin
          idx_d  = idx_q;
        end
      end
      MC_READ: begin
        if (idx_q != 3'd0) begin
          data_d[{lane_s, 3'b000} +: 8] = bus.mem_din;
        end else begin
          data_d = data_q;
        end
        if (idx_q < act_q.len) begin
          idx_d = idx_q + 3'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      MC_WRITE: begin
        if (!stall_s) begin
          idx_d = idx_q + 3'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      MC_DONE: begin
        if (port_q == PORT_DC) begin
          dc_done_d = 1'b1;
          dc_dt_d   = act_q.ls ? 32'd0 : data_q;
        end else begin
          ic_done_d = 1'b1;
          ic_dt_d   = data_q;
        end
      end
      default: idx_d = idx_q;
    endcase
  end

  // Datapath and registered done/data outputs, frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= 3'd0;
      act_q     <= '0;
      port_q    <= PORT_DC;
      data_q    <= 32'd0;
      dc_done_q <= 1'b0;
      ic_done_q <= 1'b0;
      dc_dt_q   <= 32'd0;
      ic_dt_q   <= 32'd0;
    end else if (rdy) begin
      idx_q     <= idx_d;
      act_q     <= act_d;
      port_q    <= port_d;
      data_q    <= data_d;
      dc_done_q <= dc_done_d;
      ic_done_q <= ic_done_d;
      dc_dt_q   <= dc_dt_d;
      ic_dt_q   <= ic_dt_d;
    end
  end

  // Bus drive: address during READ/WRITE byte cycles, data and strobe only in WRITE.
  always_comb begin
    mem_a_s    = '0;
    mem_dout_s = 8'd0;
    mem_wr_s   = 1'b0;
    case (state_q)
      MC_READ: begin
        if (idx_q < act_q.len) begin
          mem_a_s = cur_addr_s;
        end else begin
          mem_a_s = '0;
        end
      end
      MC_WRITE: begin
        mem_a_s    = cur_addr_s;
        mem_dout_s = byte_lane(act_q.dt, idx_q[1:0]);
        mem_wr_s   = rdy && !stall_s;
      end
      default: mem_a_s = '0;
    endcase
  end

  assign bus.mem_a    = mem_a_s;
  assign bus.mem_dout = mem_dout_s;
  assign bus.mem_wr   = mem_wr_s;
  assign bus.oDC_done = dc_done_q;
  assign bus.oDC_dt   = dc_dt_q;
  assign bus.oDC_wait = dc_wait_s;
  assign bus.oIC_done = ic_done_q;
  assign bus.oIC_dt   = ic_dt_q;
  assign bus.oIC_wait = ic_wait_s;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// loads/stores/fetches checked against a byte-array reference memory.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  mem_ctrl_if bus_if();

  mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // The memory device decodes the low 16 address bits.
  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  bit          mem_ready = 1'b0;
  logic [31:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  int          lens[3] = '{1, 2, 4};

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h0100: return 8'h11;
      16'h0101: return 8'h22;
      16'h0102: return 8'h33;
      16'h0103: return 8'h44;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // RAM model: synchronous write, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
      mem_ready <= 1'b1;
    end else if (bus_if.mem_wr) begin
      mem[bus_if.mem_a[15:0]] <= bus_if.mem_dout;
    end
    bus_if.mem_din <= mem[bus_if.mem_a[15:0]];
  end

  // Record every bus write.
  always @(negedge clk) begin
    if (bus_if.mem_wr) begin
      wr_a_q.push_back(bus_if.mem_a);
      wr_d_q.push_back(bus_if.mem_dout);
    end
  end

  // Protocol: no request pulse into a full slot.
  always @(posedge clk) begin
    if (rst && rdy && ((bus_if.iDC_en && bus_if.oDC_wait) || (bus_if.iIC_en && bus_if.oIC_wait))) begin
      failures++;
      $error("FAIL protocol pulse_while_wait dc=%0b ic=%0b", bus_if.iDC_en, bus_if.iIC_en);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] r = 32'd0;
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      r[8*i +: 8] = ref_mem[ai[15:0]];
    end
    return r;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input int n);
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      ref_mem[ai[15:0]] = d[8*i +: 8];
    end
  endfunction

  // Negedges counted from the latching edge until done is seen: dispatch is
  // one edge later, then a load takes n+2 and a store n+1 cycles.
  function automatic int exp_lat(input bit ls, input int n);
    return 1 + (ls ? n + 1 : n + 2);
  endfunction

  task automatic pulse_dc(input bit ls, input logic [31:0] pc, input logic [31:0] dt, input int n);
    @(negedge clk);
    bus_if.iDC_ls  = ls;
    bus_if.iDC_pc  = pc;
    bus_if.iDC_dt  = dt;
    bus_if.iDC_len = 3'(n);
    bus_if.iDC_en  = 1'b1;
    @(negedge clk);
    bus_if.iDC_en  = 1'b0;
    chk("dc_wait_after_pulse", {31'd0, bus_if.oDC_wait}, 32'd1);
  endtask

  task automatic pulse_ic(input logic [31:0] pc);
    @(negedge clk);
    bus_if.iIC_pc = pc;
    bus_if.iIC_en = 1'b1;
    @(negedge clk);
    bus_if.iIC_en = 1'b0;
    chk("ic_wait_after_pulse", {31'd0, bus_if.oIC_wait}, 32'd1);
  endtask

  task automatic wait_done(input bit ic, input int start, output int lat, output logic [31:0] dt);
    int c;
    c = start;
    lat = -1;
    dt = 32'hxxxx_xxxx;
    while (lat < 0 && c < 80) begin
      @(negedge clk);
      c++;
      if (ic ? bus_if.oIC_done : bus_if.oDC_done) begin
        lat = c;
        dt = ic ? bus_if.oIC_dt : bus_if.oDC_dt;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      chk("done_one_cycle", {31'd0, (ic ? bus_if.oIC_done : bus_if.oDC_done)}, 32'd0);
      chk("wait_cleared", {31'd0, (ic ? bus_if.oIC_wait : bus_if.oDC_wait)}, 32'd0);
    end
  endtask

  task automatic do_dc(input bit ls, input logic [31:0] pc, input logic [31:0] dt, input int n,
                       input string tag, output logic [31:0] got);
    int lat;
    logic [31:0] exp;
    exp = ls ? 32'd0 : ref_read(pc, n);
    if (ls) ref_write(pc, dt, n);
    pulse_dc(ls, pc, dt, n);
    wait_done(1'b0, 0, lat, got);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(ls, n)));
    chk({tag, "_dt"}, got, exp);
  endtask

  task automatic do_ic(input logic [31:0] pc, input string tag);
    int lat;
    logic [31:0] got;
    pulse_ic(pc);
    wait_done(1'b1, 0, lat, got);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(1'b0, 4)));
    chk({tag, "_dt"}, got, ref_read(pc, 4));
  endtask

  initial begin
    int          lat, c, dc_at, ic_at, io_exp, n, sel, seen;
    logic [31:0] got, dcd, icd, a, d;
    logic        icw;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
    rst = 1'b0;
    rdy = 1'b1;
    bus_if.iDC_en = 1'b0; bus_if.iDC_ls = 1'b0; bus_if.iDC_pc = 32'd0;
    bus_if.iDC_dt = 32'd0; bus_if.iDC_len = 3'd0;
    bus_if.iIC_en = 1'b0; bus_if.iIC_pc = 32'd0;
    bus_if.io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_a",   bus_if.mem_a, 32'd0);
    chk("rst_mem_wr",  {31'd0, bus_if.mem_wr}, 32'd0);
    chk("rst_oDC_dt",  bus_if.oDC_dt, 32'd0);
    chk("rst_oIC_dt",  bus_if.oIC_dt, 32'd0);
    chk("rst_waits",   {30'd0, bus_if.oDC_wait, bus_if.oIC_wait}, 32'd0);
    chk("rst_dones",   {30'd0, bus_if.oDC_done, bus_if.oIC_done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 4-byte load of the preloaded word.
    do_dc(1'b0, 32'h100, 32'd0, 4, "ld4", got);
    chk("ld4_word", got, 32'h4433_2211);

    // 2-byte store: exact byte writes on the bus, then read back.
    wr_a_q.delete(); wr_d_q.delete();
    do_dc(1'b1, 32'h200, 32'h0000_ABCD, 2, "st2", got);
    chk("st2_nwr", 32'(wr_a_q.size()), 32'd2);
    if (wr_a_q.size() == 2) begin
      chk("st2_a0", wr_a_q[0], 32'h200); chk("st2_d0", {24'd0, wr_d_q[0]}, 32'hCD);
      chk("st2_a1", wr_a_q[1], 32'h201); chk("st2_d1", {24'd0, wr_d_q[1]}, 32'hAB);
    end
    do_dc(1'b0, 32'h200, 32'd0, 2, "ld2", got);
    chk("ld2_word", got, 32'h0000_ABCD);

    // Simultaneous dcache/icache pulses: dcache first, icache after.
    @(negedge clk);
    bus_if.iDC_ls = 1'b0; bus_if.iDC_pc = 32'h10; bus_if.iDC_len = 3'd1; bus_if.iDC_en = 1'b1;
    bus_if.iIC_pc = 32'h0; bus_if.iIC_en = 1'b1;
    @(negedge clk);
    bus_if.iDC_en = 1'b0; bus_if.iIC_en = 1'b0;
    chk("sim_waits", {30'd0, bus_if.oDC_wait, bus_if.oIC_wait}, 32'd3);
    dc_at = -1; ic_at = -1; icw = 1'b0; dcd = 32'd0; icd = 32'd0;
    for (c = 1; c <= 40 && (dc_at < 0 || ic_at < 0); c++) begin
      @(negedge clk);
      if (bus_if.oDC_done && dc_at < 0) begin dc_at = c; dcd = bus_if.oDC_dt; icw = bus_if.oIC_wait; end
      if (bus_if.oIC_done && ic_at < 0) begin ic_at = c; icd = bus_if.oIC_dt; end
    end
    chk("sim_dc_lat", 32'(dc_at), 32'(exp_lat(1'b0, 1)));
    chk("sim_ic_lat", 32'(ic_at), 32'(exp_lat(1'b0, 1) + exp_lat(1'b0, 4)));
    chk("sim_ic_wait_at_dc_done", {31'd0, icw}, 32'd1);
    chk("sim_dc_dt", dcd, ref_read(32'h10, 1));
    chk("sim_ic_dt", icd, ref_read(32'h0, 4));

    // Store of one byte into IO space while the IO buffer is full.
`ifdef MEMCTRL_IO_STALL_EN
    io_exp = exp_lat(1'b1, 1) + 3;
`else
    io_exp = exp_lat(1'b1, 1);
`endif
    ref_write(32'h0003_0004, 32'h5C, 1);
    bus_if.io_buffer_full = 1'b1;
    pulse_dc(1'b1, 32'h0003_0004, 32'h5C, 1);
    lat = -1;
    for (c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (bus_if.oDC_done) lat = c;
      if (c == 2) chk("io_stall_wr", {31'd0, bus_if.mem_wr}, 32'd0);
      if (c == 4) bus_if.io_buffer_full = 1'b0;
    end
    bus_if.io_buffer_full = 1'b0;
    chk("io_lat", 32'(lat), 32'(io_exp));
    @(negedge clk);
    do_dc(1'b0, 32'h0003_0004, 32'd0, 1, "io_ld", got);

    // Reset in the middle of a 4-byte read at idx 2.
    pulse_dc(1'b0, 32'h100, 32'd0, 4);
    repeat (3) @(negedge clk);
    chk("rstmid_addr", bus_if.mem_a, 32'h102);
    rst = 1'b0;
    #1;
    chk("rstmid_mem_a",  bus_if.mem_a, 32'd0);
    chk("rstmid_oDC_dt", bus_if.oDC_dt, 32'd0);
    chk("rstmid_misc",   {26'd0, bus_if.oDC_done, bus_if.oIC_done, bus_if.oDC_wait,
                          bus_if.oIC_wait, bus_if.mem_wr, |bus_if.mem_dout}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.oDC_done) seen++;
    end
    chk("rstmid_no_done", 32'(seen), 32'd0);
    do_dc(1'b0, 32'h100, 32'd0, 4, "post_rst", got);

    // rdy low for two cycles in the middle of a 4-byte store.
    ref_write(32'h500, 32'hDEAD_BEEF, 4);
    pulse_dc(1'b1, 32'h500, 32'hDEAD_BEEF, 4);
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    #1;
    chk("rdy_wr_low", {31'd0, bus_if.mem_wr}, 32'd0);
    @(negedge clk);
    chk("rdy_hold_a3", bus_if.mem_a, 32'h501);
    @(negedge clk);
    chk("rdy_hold_a4", bus_if.mem_a, 32'h501);
    rdy = 1'b1;
    wait_done(1'b0, 4, lat, got);
    chk("rdy_lat", 32'(lat), 32'(exp_lat(1'b1, 4) + 2));
    do_dc(1'b0, 32'h500, 32'd0, 4, "rdy_ld", got);
    chk("rdy_word", got, 32'hDEAD_BEEF);

    // Randomized traffic, including address wrap at 2^32.
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 2);
      n   = lens[$urandom_range(0, 2)];
      if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
      else                           a = 32'h400 + 32'($urandom_range(0, 31));
      d = $urandom;
      case (sel)
        0:       do_dc(1'b0, a, 32'd0, n, "rnd_ld", got);
        1:       do_dc(1'b1, a, d, n, "rnd_st", got);
        default: do_ic(a, "rnd_if");
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
